ibe_level1: RTL and testbench

//  Final inverse-butterfly recombination for the IDCT (reverse of the forward level-1 even/odd split).

---
 rtl/ibe_level1_if.sv | 29 ++
 rtl/ibe_level1.sv | 122 ++++++++++++
 tb/tb_ibe_level1.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ibe_level1_if.sv
// Beat-level bus for the IDCT level-1 inverse butterfly: input E/O lanes with
// valid/ready, output spatial samples with valid/ready.
interface ibe_level1_if #(
  parameter int IW = 28,
  parameter int OW = 16
);
  logic             i_valid;
  logic             i_ready;
  logic [1:0]       i_transize;
  logic [3:0]       i_shift;
  logic [16*IW-1:0] i_even;
  logic [16*IW-1:0] i_odd;
  logic             o_valid;
  logic             i_out_ready;
  logic [1:0]       o_transize;
  logic [32*OW-1:0] o_data;

  // Upstream/downstream side of the block
  modport master (
    output i_valid, i_transize, i_shift, i_even, i_odd, i_out_ready,
    input  i_ready, o_valid, o_transize, o_data
  );

  // The recombination block itself
  modport slave (
    input  i_valid, i_transize, i_shift, i_even, i_odd, i_out_ready,
    output i_ready, o_valid, o_transize, o_data
  );
endinterface

// File: rtl/ibe_level1.sv
// IDCT level-1 inverse butterfly: Y[k]=E+O / Y[N-1-k]=E-O, then round,
// shift and clip; two-stage pipeline with valid/ready backpressure.
module ibe_level1 #(
  parameter int IW = 28,
  parameter int OW = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  ibe_level1_if.slave  bus
);

  localparam logic signed [IW+1:0] MAXV = {{(IW+3-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW+1:0] MINV = {{(IW+3-OW){1'b1}}, {(OW-1){1'b0}}};

  logic                 adv1;
  logic                 adv2;
  logic signed [IW:0]   ev   [16];
  logic signed [IW:0]   od   [16];
  logic signed [IW:0]   s_d  [32];
  logic signed [IW:0]   s_q  [32];
  logic                 v1_q;
  logic [1:0]           size1_q;
  logic [3:0]           shift1_q;
  logic [32*OW-1:0]     y_d;
  logic [32*OW-1:0]     y_q;
  logic                 ov_q;
  logic [1:0]           osize_q;

  // Rounding is done one bit wider than S so the +half cannot wrap near full scale.
  function automatic logic [OW-1:0] round_clip(input logic signed [IW:0] s,
                                               input logic [3:0]       sh);
    logic signed [IW+1:0] t;
    logic signed [IW+1:0] rnd;
    rnd = '0;
    if (sh != 4'd0) rnd[sh - 4'd1] = 1'b1;
    t = {s[IW], s};
    t = t + rnd;
    t = t >>> sh;
    if (t > MAXV)      return MAXV[OW-1:0];
    else if (t < MINV) return MINV[OW-1:0];
    else               return t[OW-1:0];
  endfunction

  assign adv2          = !ov_q || bus.i_out_ready;
  assign adv1          = !v1_q || adv2;
  assign bus.i_ready   = adv1;
  assign bus.o_valid   = ov_q;
  assign bus.o_data    = y_q;
  assign bus.o_transize = osize_q;

  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      ev[k] = {bus.i_even[k*IW + IW - 1], bus.i_even[k*IW +: IW]};
      od[k] = {bus.i_odd[k*IW + IW - 1],  bus.i_odd[k*IW +: IW]};
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 32; k++) s_d[k] = '0;
    case (bus.i_transize)
      2'd3: begin
        for (int unsigned k = 0; k < 16; k++) begin
          s_d[k]      = ev[k] + od[k];
          s_d[31 - k] = ev[k] - od[k];
        end
      end
      2'd2: begin
        // Two independent 16-point rows packed into the 32 output lanes
        for (int unsigned k = 0; k < 8; k++) begin
          s_d[k]      = ev[k] + od[k];
          s_d[15 - k] = ev[k] - od[k];
          s_d[16 + k] = ev[8 + k] + od[8 + k];
          s_d[31 - k] = ev[8 + k] - od[8 + k];
        end
      end
      default: begin
        for (int unsigned k = 0; k < 16; k++) begin
          s_d[k]      = ev[k];
          s_d[16 + k] = od[k];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      size1_q  <= '0;
      shift1_q <= '0;
      for (int unsigned k = 0; k < 32; k++) s_q[k] <= '0;
    end else if (adv1) begin
      v1_q <= bus.i_valid;
      if (bus.i_valid) begin
        size1_q  <= bus.i_transize;
        shift1_q <= bus.i_shift;
        for (int unsigned k = 0; k < 32; k++) s_q[k] <= s_d[k];
      end
    end
  end

  always_comb begin
    y_d = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      y_d[k*OW +: OW] = round_clip(s_q[k], shift1_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q    <= 1'b0;
      osize_q <= '0;
      y_q     <= '0;
    end else if (adv2) begin
      ov_q <= v1_q;
      if (v1_q) begin
        osize_q <= size1_q;
        y_q     <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_ibe_level1.sv
// Directed bench for ibe_level1: hand-computed lane values, latency,
// backpressure ordering/stability and asynchronous reset mid-stream.
module tb_ibe_level1;

  localparam int IW = 28;
  localparam int OW = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  logic signed [IW-1:0] E [16];
  logic signed [IW-1:0] O [16];
  int                   exp_y [32];

  ibe_level1_if #(.IW(IW), .OW(OW)) bus ();

  ibe_level1 #(.IW(IW), .OW(OW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic signed [OW-1:0] y(input int k);
    return bus.o_data[k*OW +: OW];
  endfunction

  task automatic clear_vec();
    for (int k = 0; k < 16; k++) begin
      E[k] = '0;
      O[k] = '0;
    end
    for (int k = 0; k < 32; k++) exp_y[k] = 0;
  endtask

  task automatic pack(input logic [1:0] ts, input logic [3:0] sh);
    for (int k = 0; k < 16; k++) begin
      bus.i_even[k*IW +: IW] = E[k];
      bus.i_odd[k*IW +: IW]  = O[k];
    end
    bus.i_transize = ts;
    bus.i_shift    = sh;
  endtask

  // Present one beat with the sink ready; checks 2-cycle latency and size tag.
  task automatic one_beat(input string tag, input logic [1:0] ts, input logic [3:0] sh);
    pack(ts, sh);
    bus.i_out_ready = 1'b1;
    bus.i_valid     = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check({tag, "_ov_lat1"}, bus.o_valid, 0);
    @(posedge clk); #1;
    check({tag, "_ov_lat2"}, bus.o_valid, 1);
    check({tag, "_tsize"}, bus.o_transize, ts);
  endtask

  task automatic check_lanes(input string tag);
    for (int k = 0; k < 32; k++) check($sformatf("%s_y%0d", tag, k), y(k), exp_y[k]);
  endtask

  initial begin
    int sent, rcv, inflight, cyc;
    logic acc, dlv, prev_stall;
    logic signed [OW-1:0] prev_y0;
    logic [1:0] prev_ts;

    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_out_ready = 1'b0;
    bus.i_transize  = '0;
    bus.i_shift     = '0;
    bus.i_even      = '0;
    bus.i_odd       = '0;
    clear_vec();

    #3;
    check("rst_ov", bus.o_valid, 0);
    check("rst_data", (bus.o_data == '0), 1);
    check("rst_tsize", bus.o_transize, 0);
    #19 rst_n = 1'b1;
    #1;
    check("rst_iready", bus.i_ready, 1);

    // 32-point: E[k]=128k, O[k]=64, shift 7
    clear_vec();
    for (int k = 0; k < 16; k++) begin
      E[k] = 28'(128 * k);
      O[k] = 28'sd64;
      exp_y[k]      = k + 1;
      exp_y[31 - k] = k;
    end
    one_beat("p32", 2'd3, 4'd7);
    check_lanes("p32");

    // 16-point: two rows
    clear_vec();
    E[0] = 28'sd1000; O[0] = 28'sd200; E[8] = -28'sd1000; O[8] = 28'sd200;
    exp_y[0] = 1200; exp_y[15] = 800; exp_y[16] = -800; exp_y[31] = -1200;
    one_beat("p16", 2'd2, 4'd0);
    check_lanes("p16");

    // Bypass 4x4
    clear_vec();
    E[3] = 28'sd5; O[3] = -28'sd7;
    exp_y[3] = 5; exp_y[19] = -7;
    one_beat("byp", 2'd0, 4'd0);
    check_lanes("byp");

    // Clipping
    clear_vec();
    E[0] = 28'sd1048576; O[0] = 28'sd1048576;
    one_beat("clipp", 2'd3, 4'd0);
    check("clipp_y0", y(0), 32767);
    check("clipp_y31", y(31), 0);
    clear_vec();
    E[0] = -28'sd1048576;
    one_beat("clipn", 2'd3, 4'd0);
    check("clipn_y0", y(0), -32768);
    check("clipn_y31", y(31), -32768);

    // Rounding through the bypass path (S = E[0])
    clear_vec();
    E[0] = -28'sd3;
    one_beat("rnd_m3", 2'd1, 4'd1);
    check("rnd_m3_y0", y(0), -1);
    E[0] = 28'sd3;
    one_beat("rnd_p3", 2'd1, 4'd1);
    check("rnd_p3_y0", y(0), 2);
    E[0] = -28'sd67108864;
    one_beat("rnd_big", 2'd0, 4'd12);
    check("rnd_big_y0", y(0), -16384);

    // Full-scale S with max shift: rounding must not wrap
    clear_vec();
    E[0] = 28'sd134217727; O[0] = 28'sd134217727;
    one_beat("fs_pos", 2'd3, 4'd12);
    check("fs_pos_y0", y(0), 32767);
    check("fs_pos_y31", y(31), 0);
    E[0] = -28'sd134217728; O[0] = -28'sd134217728;
    one_beat("fs_neg", 2'd3, 4'd12);
    check("fs_neg_y0", y(0), -32768);
    check("fs_neg_y31", y(31), 0);

    // Illegal shift still produces a beat
    clear_vec();
    E[0] = 28'sd100;
    one_beat("sh13", 2'd0, 4'd13);

    // Back-to-back beats with a size change
    clear_vec();
    E[0] = 28'sd10; O[0] = 28'sd3;
    pack(2'd3, 4'd0);
    bus.i_out_ready = 1'b1;
    bus.i_valid     = 1'b1;
    @(posedge clk); #1;
    pack(2'd0, 4'd0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("b2b_a_ov", bus.o_valid, 1);
    check("b2b_a_ts", bus.o_transize, 3);
    check("b2b_a_y0", y(0), 13);
    check("b2b_a_y31", y(31), 7);
    @(posedge clk); #1;
    check("b2b_b_ov", bus.o_valid, 1);
    check("b2b_b_ts", bus.o_transize, 0);
    check("b2b_b_y0", y(0), 10);
    check("b2b_b_y16", y(16), 3);
    @(posedge clk); #1;
    check("b2b_drain", bus.o_valid, 0);

    // Backpressure: 10 tagged beats, random sink stalls
    clear_vec();
    sent = 0; rcv = 0; inflight = 0; cyc = 0;
    prev_stall = 1'b0; prev_y0 = '0; prev_ts = '0;
    while (rcv < 10 && cyc < 400) begin
      bus.i_out_ready = 1'($urandom_range(0, 1));
      bus.i_valid     = (sent < 10);
      E[0] = 28'(sent);
      pack(2'd1, 4'd0);
      #3;
      check("bp_iready", bus.i_ready, !(inflight == 2 && !bus.i_out_ready));
      if (prev_stall) begin
        check("bp_hold_ov", bus.o_valid, 1);
        check("bp_hold_y0", y(0), prev_y0);
        check("bp_hold_ts", bus.o_transize, prev_ts);
      end
      acc = bus.i_valid && bus.i_ready;
      dlv = bus.o_valid && bus.i_out_ready;
      if (dlv) begin
        check("bp_order", y(0), rcv);
        rcv++;
      end
      if (acc) sent++;
      inflight   = inflight + int'(acc) - int'(dlv);
      prev_stall = bus.o_valid && !bus.i_out_ready;
      prev_y0    = y(0);
      prev_ts    = bus.o_transize;
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_valid = 1'b0;
    check("bp_count", rcv, 10);
    check("bp_sent", sent, 10);
    bus.i_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_no_extra", bus.o_valid, 0);

    // Reset with both stages full
    clear_vec();
    bus.i_out_ready = 1'b0;
    E[0] = 28'sd77;
    pack(2'd3, 4'd0);
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    E[0] = 28'sd78;
    pack(2'd3, 4'd0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("mid_full_ov", bus.o_valid, 1);
    check("mid_full_ir", bus.i_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", bus.o_valid, 0);
    check("mid_rst_data", (bus.o_data == '0), 1);
    check("mid_rst_ts", bus.o_transize, 0);
    #10 rst_n = 1'b1;
    bus.i_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_ov%0d", i), bus.o_valid, 0);
      check($sformatf("post_rst_ir%0d", i), bus.i_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
